instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetches 64-bit instructions from the per-processing-block L0 instruction memory (8192 entries, synchronous read) and presents them in order, with their PC, to the decode stage over a valid/ready handshake. It is the read-side client of the instruction memory: it owns the program counter, supports redirects, and stops at an EXIT instruction. It sits between the instruction memory and the decoder in each processing block.

## Interface
- INSTRUCTION_WIDTH, 64, instruction word width (from gpu_parameters)
- INSTRUCTION_MEMORY_ADDRESS_WIDTH, 13, PC/address width (from gpu_parameters)
- OPCODE_WIDTH, 8, opcode field width; opcode = inst[63:56]
- FIFO_DEPTH, 2, output buffer entries
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; in IDLE loads start_pc and begins fetching
- start_pc  in  13  initial PC
- redirect_valid  in  1  pulse; flush and resume at redirect_pc (RUN or HALTED)
- redirect_pc  in  13  redirect target
- imem_rd_en  out  1  read request this cycle
- imem_rd_addr  out  13  read address
- imem_rd_data  in  64  read data, valid exactly 1 cycle after imem_rd_en
- inst_valid  out  1  instruction available
- inst_ready  in  1  decoder accepts
- inst_data  out  64  instruction word
- inst_pc  out  13  PC of inst_data
- busy  out  1  state == RUN
- halted  out  1  state == HALTED

## Operation
- FSM states IDLE, RUN, HALTED. Reset → IDLE.
- IDLE: no reads; start → RUN, pc ← start_pc. redirect ignored.
- RUN: imem_rd_en = 1 when occupancy + in_flight < FIFO_DEPTH; address = pc; pc ← pc + 1 (wraps 8191 → 0).
- Returning data is tagged with its PC and pushed into the FIFO on the cycle after the read, unless squashed.
- Handshake: transfer when inst_valid && inst_ready; inst_data/inst_pc stable while inst_valid && !inst_ready.
- EXIT detection: opcode 8'hFF on returning data → data pushed normally, fetch stops, state → HALTED; no further reads. HALTED entries still drain normally.
- Redirect (RUN or HALTED): FIFO cleared, in-flight read squashed, pc ← redirect_pc, state → RUN; reads resume the same cycle it is applied (next edge). Redirect wins over simultaneous EXIT return and over a simultaneous pop (pop still counts as consumed by decoder; entry is discarded).
- Simultaneous push and pop with full FIFO: not possible by credit rule; push and pop in same cycle at occupancy 1 keeps occupancy 1.
- Reset asserted mid-operation: all state cleared immediately, in-flight data discarded.

## Timing
- Reset values: imem_rd_en 0, imem_rd_addr 0, inst_valid 0, inst_data 0, inst_pc 0, busy 0, halted 0.
- start at edge N → first imem_rd_en in cycle N+1, inst_valid in cycle N+2 (fetch-to-output latency 1 cycle after read).
- Steady state with inst_ready held 1: one instruction per cycle, no bubbles.
- Redirect at edge N → read of redirect_pc in cycle N+1, inst_valid with that PC in cycle N+2; nothing older appears after edge N.
- EXIT returned at edge N → halted = 1 from cycle N+1; no imem_rd_en from cycle N+1 onward (one speculative read issued in cycle N is squashed).

## Structure
- FIFO_DEPTH, EXIT opcode constant (OPCODE_EXIT = 8'hFF), and fetch_state_t enum go in gpu_parameters.
- One sub-module: fetch_fifo (synchronous FIFO, data+PC, flush input, depth parameter).

## Test plan
- Reset, start_pc=0x0010, inst_ready=1 → inst_pc 0x0010, 0x0011, 0x0012 on consecutive cycles from cycle 2.
- inst_ready=0 for 5 cycles → at most 2 buffered, imem_rd_en low once full, no loss/duplication on release.
- start_pc=0x1FFE → inst_pc 0x1FFE, 0x1FFF, 0x0000 (wrap).
- EXIT at 0x0005 (start 0x0003) → 0x0003..0x0005 delivered, halted=1, no reads after, 0x0006 never output.
- redirect_pc=0x0100 while FIFO full and read in flight → next inst_pc is 0x0100; redirect from HALTED restarts RUN.
- rst_n low mid-stream → all outputs 0 asynchronously; after release stays IDLE until start.

Source files
------------

// File: rtl/gpu_parameters.sv
// Shared widths, constants and types for the processing-block fetch path.
package gpu_parameters;

  localparam int INSTRUCTION_WIDTH                = 64;
  localparam int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 13;
  localparam int OPCODE_WIDTH                     = 8;
  localparam int FIFO_DEPTH                       = 2;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_EXIT = 8'hFF;

  typedef logic [INSTRUCTION_WIDTH-1:0]                inst_word_t;
  typedef logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] imem_addr_t;

  typedef struct packed {
    inst_word_t inst;
    imem_addr_t pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_HALTED
  } fetch_state_t;

  function automatic logic is_exit(input inst_word_t word);
    return word[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] == OPCODE_EXIT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions with their PCs.
// Flush empties it in one cycle; the producer never pushes when full.
module fetch_fifo
  import gpu_parameters::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, reads the L0 instruction memory and hands instructions in order
// to decode; supports redirects and stops after an EXIT instruction.
module instruction_fetch_unit
  import gpu_parameters::*;
(
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] start_pc,
  input  logic                                        redirect_valid,
  input  logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                                        imem_rd_en,
  output logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] imem_rd_addr,
  input  logic [INSTRUCTION_WIDTH-1:0]                imem_rd_data,
  output logic                                        inst_valid,
  input  logic                                        inst_ready,
  output logic [INSTRUCTION_WIDTH-1:0]                inst_data,
  output logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] inst_pc,
  output logic                                        busy,
  output logic                                        halted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t state_q, state_d;
  imem_addr_t   pc_q, pc_d;
  logic         inflight_q, inflight_d;
  imem_addr_t   inflight_pc_q, inflight_pc_d;

  fetch_entry_t     fifo_head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push, fifo_pop, redirect_en, ret_exit, credit_ok;
  logic [CNT_W:0]   credit_used;

  // Returning data bypasses the empty FIFO so a read shows up on the very next cycle.
  always_comb begin
    redirect_en = redirect_valid && (state_q != FETCH_IDLE);
    ret_exit    = inflight_q && is_exit(imem_rd_data);
    credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);

    inst_valid = !fifo_empty || inflight_q;
    inst_data  = '0;
    inst_pc    = '0;
    if (!fifo_empty) begin
      inst_data = fifo_head.inst;
      inst_pc   = fifo_head.pc;
    end else if (inflight_q) begin
      inst_data = imem_rd_data;
      inst_pc   = inflight_pc_q;
    end

    fifo_pop  = !fifo_empty && inst_ready;
    fifo_push = inflight_q && !redirect_en && !(fifo_empty && inst_ready);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    imem_rd_en    = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        if (start) begin
          state_d = FETCH_RUN;
          pc_d    = start_pc;
        end
      end
      FETCH_RUN: begin
        imem_rd_en = credit_ok;
        if (credit_ok) begin
          pc_d          = pc_q + imem_addr_t'(1);
          inflight_d    = 1'b1;
          inflight_pc_d = pc_q;
        end
        // The read issued alongside a returning EXIT is speculative and dropped.
        if (ret_exit) begin
          state_d    = FETCH_HALTED;
          inflight_d = 1'b0;
        end
      end
      FETCH_HALTED: ;
      default: state_d = FETCH_IDLE;
    endcase

    if (redirect_en) begin
      state_d    = FETCH_RUN;
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_en),
    .push_i      (fifo_push),
    .push_entry_i('{inst: imem_rd_data, pc: inflight_pc_q}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign imem_rd_addr = pc_q;
  assign busy         = (state_q == FETCH_RUN);
  assign halted       = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: in-order program-stream model plus directed timing points,
// followed by randomized backpressure, redirects, starts and EXITs.
module tb_instruction_fetch_unit;
  import gpu_parameters::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] start_pc = '0;
  logic        redirect_valid = 1'b0;
  logic [12:0] redirect_pc = '0;
  logic        imem_rd_en;
  logic [12:0] imem_rd_addr;
  logic [63:0] imem_rd_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] inst_data;
  logic [12:0] inst_pc;
  logic        busy;
  logic        halted;

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_pc      (start_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_rd_en    (imem_rd_en),
    .imem_rd_addr  (imem_rd_addr),
    .imem_rd_data  (imem_rd_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .busy          (busy),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous read, data one cycle after the request.
  logic [63:0] mem [8192];
  always @(posedge clk) if (imem_rd_en) imem_rd_data <= mem[imem_rd_addr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, imem_rd_en, 0);
    check({tag, "_rd_addr"}, imem_rd_addr, 0);
    check({tag, "_valid"}, inst_valid, 0);
    check({tag, "_data"}, inst_data, 0);
    check({tag, "_pc"}, inst_pc, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  function automatic bit op_exit(input logic [63:0] w);
    return w[63:56] == 8'hFF;
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[63:56] = 8'($urandom_range(0, 254));
    return w;
  endfunction

  // Program-order model: what the fetcher must read and deliver, per interval.
  typedef enum {M_IDLE, M_RUN, M_HALTED} mstate_e;
  mstate_e     m_state = M_IDLE;
  logic [12:0] m_fetch_pc = '0;
  logic [12:0] m_out_pc = '0;
  bit          m_out_done = 0;
  bit          m_exit_pending = 0;
  int          m_issued = 0;
  int          m_accepted = 0;
  bit          hold_prev = 0;
  logic [12:0] hold_pc = '0;
  logic [63:0] hold_data = '0;

  always @(negedge clk) begin
    bit next_pending;
    if (!rst_n) begin
      m_state        = M_IDLE;
      m_out_done     = 0;
      m_exit_pending = 0;
      m_issued       = 0;
      m_accepted     = 0;
      hold_prev      = 0;
    end else begin
      check("busy", busy, m_state == M_RUN);
      check("halted", halted, m_state == M_HALTED);
      check("outstanding_le_depth", (m_issued - m_accepted) <= FIFO_DEPTH, 1);
      if (hold_prev)
        check("hold_stable", inst_valid && inst_pc == hold_pc && inst_data == hold_data, 1);
      if (imem_rd_en) begin
        check("rd_only_in_run", m_state == M_RUN, 1);
        check("rd_addr", imem_rd_addr, m_fetch_pc);
      end
      if (inst_valid && inst_ready) begin
        check("out_after_exit", m_out_done, 0);
        check("out_pc", inst_pc, m_out_pc);
        check("out_data", inst_data, mem[m_out_pc]);
        if (op_exit(mem[m_out_pc])) m_out_done = 1;
        m_out_pc++;
        m_accepted++;
      end
      hold_prev = inst_valid && !inst_ready;
      hold_pc   = inst_pc;
      hold_data = inst_data;

      if (redirect_valid && m_state != M_IDLE) begin
        m_state        = M_RUN;
        m_fetch_pc     = redirect_pc;
        m_out_pc       = redirect_pc;
        m_out_done     = 0;
        m_exit_pending = 0;
        m_issued       = 0;
        m_accepted     = 0;
        hold_prev      = 0;
      end else if (m_state == M_IDLE) begin
        if (start) begin
          m_state        = M_RUN;
          m_fetch_pc     = start_pc;
          m_out_pc       = start_pc;
          m_out_done     = 0;
          m_exit_pending = 0;
          m_issued       = 0;
          m_accepted     = 0;
        end
      end else begin
        next_pending = 0;
        if (imem_rd_en) begin
          next_pending = (m_state == M_RUN) && op_exit(mem[m_fetch_pc]);
          m_fetch_pc++;
          m_issued++;
        end
        if (m_exit_pending) m_state = M_HALTED;
        m_exit_pending = next_pending;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = rand_word();
    mem[13'h0010] = 64'h0123_4567_89AB_CDEF;

    // Reset values
    repeat (2) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_busy", busy, 0);
    check("idle_rd_en", imem_rd_en, 0);

    // Start at 0x0010, streaming with inst_ready high
    start_pc = 13'h0010; start = 1'b1; inst_ready = 1'b1;
    step(); start = 1'b0;
    check("start_rd_en", imem_rd_en, 1);
    check("start_rd_addr", imem_rd_addr, 13'h0010);
    check("start_valid_early", inst_valid, 0);
    step();
    check("first_valid", inst_valid, 1);
    check("first_pc", inst_pc, 13'h0010);
    check("first_data", inst_data, 64'h0123_4567_89AB_CDEF);
    step(); check("second_pc", inst_pc, 13'h0011);
    step(); check("third_pc", inst_pc, 13'h0012);

    // Backpressure for five cycles
    step(); inst_ready = 1'b0;
    check("stall_pc", inst_pc, 13'h0013);
    repeat (4) step();
    check("stall_valid", inst_valid, 1);
    check("stall_pc_held", inst_pc, 13'h0013);
    check("stall_full_no_read", imem_rd_en, 0);
    inst_ready = 1'b1;
    step(); check("release_pc0", inst_pc, 13'h0014);
    step(); check("release_pc1", inst_pc, 13'h0015);

    // Asynchronous reset mid-stream
    repeat (3) step();
    rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    check("post_reset_busy", busy, 0);
    check("post_reset_rd_en", imem_rd_en, 0);
    check("post_reset_valid", inst_valid, 0);

    // PC wrap
    start_pc = 13'h1FFE; start = 1'b1;
    step(); start = 1'b0;
    step(); check("wrap_pc0", inst_pc, 13'h1FFE);
    step(); check("wrap_pc1", inst_pc, 13'h1FFF);
    step(); check("wrap_pc2", inst_pc, 13'h0000);

    // EXIT at 0x0005, starting at 0x0003
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    mem[13'h0005] = {8'hFF, 56'h00_1234_5678_9ABC};
    start_pc = 13'h0003; start = 1'b1;
    step(); start = 1'b0;
    step(); check("exit_pc3", inst_pc, 13'h0003);
    step(); check("exit_pc4", inst_pc, 13'h0004);
    step();
    check("exit_pc5", inst_pc, 13'h0005);
    check("exit_spec_rd", imem_rd_en, 1);
    check("exit_spec_addr", imem_rd_addr, 13'h0006);
    check("exit_not_yet_halted", halted, 0);
    step();
    check("exit_halted", halted, 1);
    check("exit_no_rd", imem_rd_en, 0);
    check("exit_no_valid", inst_valid, 0);
    repeat (5) step();
    check("halted_still_no_rd", imem_rd_en, 0);

    // Redirect out of HALTED
    redirect_pc = 13'h0040; redirect_valid = 1'b1;
    step(); redirect_valid = 1'b0;
    check("redir_busy", busy, 1);
    check("redir_rd_addr", imem_rd_addr, 13'h0040);
    check("redir_rd_en", imem_rd_en, 1);
    check("redir_no_old", inst_valid, 0);
    step(); check("redir_pc", inst_pc, 13'h0040);

    // Redirect with the FIFO full
    inst_ready = 1'b0;
    repeat (4) step();
    check("full_no_read", imem_rd_en, 0);
    redirect_pc = 13'h0100; redirect_valid = 1'b1;
    step(); redirect_valid = 1'b0; inst_ready = 1'b1;
    check("flush_no_old", inst_valid, 0);
    check("flush_rd_addr", imem_rd_addr, 13'h0100);
    step();
    check("flush_valid", inst_valid, 1);
    check("flush_pc", inst_pc, 13'h0100);

    // Randomized phase with sparse EXITs
    rst_n = 1'b0;
    for (int i = 0; i < 40; i++) mem[$urandom_range(0, 8191)][63:56] = 8'hFF;
    step(); rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 60) == 0) || (halted && $urandom_range(0, 3) == 0);
      redirect_pc    = 13'($urandom);
      start          = ($urandom_range(0, 20) == 0);
      start_pc       = 13'($urandom);
      step();
    end
    redirect_valid = 1'b0;
    start = 1'b0;
    inst_ready = 1'b1;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
